// File: rtl/mux_pkg.sv
// Shared constants and result type for the registered 32:1 bit selector.
// Both the RTL and the bench import this package.
package mux_pkg;

    localparam int N_IN  = 32;
    localparam int SEL_W = 5;

    // One registered sample: data bit plus the flag marking it as fresh.
    typedef struct packed {
        logic valid;
        logic data;
    } mux_result_t;

endpackage

// File: rtl/mux_2to1.sv
// Single-bit 2:1 multiplexer, the leaf cell of the selector tree.
// Purely combinational: s=0 passes a, s=1 passes b.
module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_32_to_1.sv
// Registered 32:1 bit selector: a binary tree of mux_2to1 cells picks inp[sel],
// and a single output register stage captures it whenever in_valid is high.
module mux_32_to_1 #(
    parameter int N_IN  = mux_pkg::N_IN,
    parameter int SEL_W = mux_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  inp,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic             out,
    output logic             out_valid
);

    import mux_pkg::*;

    localparam int N_NODE = 2 * N_IN - 1;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2, node 0 is the root,
    // and the top N_IN entries are the raw inputs in index order.
    wire [N_NODE-1:0] node;
    logic             mux_val;

    assign node[N_NODE-1:N_IN-1] = inp;

    // Depth d from the root is tree level SEL_W-1-d counted from the leaves,
    // so the leaf-side muxes steer on sel[0] and the root on the MSB.
    for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int IDX = (1 << d) - 1 + j;
            mux_2to1 u_mux (
                .a (node[2*IDX+1]),
                .b (node[2*IDX+2]),
                .s (sel[SEL_W-1-d]),
                .y (node[IDX])
            );
        end
    end

    assign mux_val = node[0];

    // Handshake: in_valid=1 means inp/sel are sampled on this rising edge;
    // out_valid follows one cycle later for exactly one cycle per sample.
    // There is no ready -- every valid sample is accepted.
    mux_result_t res_q, res_d;

    always_comb begin
        res_d.valid = in_valid;
        res_d.data  = res_q.data;
        if (in_valid) begin
            res_d.data = mux_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign out       = res_q.data;
    assign out_valid = res_q.valid;

endmodule

// File: tb/tb_mux_32_to_1.sv
// Self-checking bench for mux_32_to_1: a cycle model of "out = inp[sel] from the
// last valid edge" is compared every cycle, plus hand-computed literal results.
module tb_mux_32_to_1;

    import mux_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IN-1:0]  inp;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             out;
    logic             out_valid;

    always #5 clk = ~clk;

    mux_32_to_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inp       (inp),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       m_out    = 1'b0;
    logic       m_valid  = 1'b0;
    logic [1:0] exp_q[$];   // {has_literal, literal_value} per accepted sample

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic ref_bit(input logic [N_IN-1:0] v, input logic [SEL_W-1:0] s);
        logic [N_IN-1:0] shifted;
        shifted = v >> s;
        return shifted[0];
    endfunction

    // Model: what out/out_valid must show after each rising edge.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_valid = in_valid;
            if (in_valid) m_out = ref_bit(inp, sel);
        end
    end

    always @(negedge rst_n) begin
        m_out   = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e;
        check("out_vs_model", out, m_out);
        check("valid_vs_model", out_valid, m_valid);
        if (rst_n === 1'b1 && m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL exp_q_underflow: got empty queue, required a pending entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e[1]) check("out_literal", out, e[0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [N_IN-1:0] v, input logic [SEL_W-1:0] s,
                         input logic vld, input logic has_lit, input logic lit);
        @(posedge clk);
        #2;
        inp      = v;
        sel      = s;
        in_valid = vld;
        if (vld) exp_q.push_back({has_lit, lit});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        inp      = 32'hFFFF_FFFF;
        sel      = '0;

        // Reset held with live inputs: outputs must stay zero.
        repeat (4) begin
            @(negedge clk);
            check("reset_out", out, 1'b0);
            check("reset_valid", out_valid, 1'b0);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // All-zero and all-one inputs.
        drive(32'h0000_0000, 5'd0, 1'b1, 1'b1, 1'b0);
        drive(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("zero_case_out", out, 1'b0);
        check("zero_case_valid", out_valid, 1'b1);

        // Walking one, selected bit and its neighbour.
        for (int k = 0; k < 32; k++)
            drive(32'(1) << k, 5'(k), 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 32; k++)
            drive(32'(1) << k, 5'((k + 1) % 32), 1'b1, 1'b1, 1'b0);

        // Hold with in_valid low while inputs change.
        drive(32'hA5A5_A5A5, 5'd0, 1'b1, 1'b1, 1'b1);
        drive(32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0000, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_out", out, 1'b1);
        check("hold_valid", out_valid, 1'b0);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", out, 1'b0);
        check("async_reset_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_valid", out_valid, 1'b0);
        check("post_reset_out", out, 1'b0);

        // Random back-to-back samples, checked against the model.
        repeat (24)
            drive($urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0);
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_q_drained: got %0d pending entries, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_32_to_1.md
MUX_32_TO_1 -- requirements
Module: mux_32_to_1

Interface
REQ-001 Parameter N_IN, default 32, meaning number of data inputs; only 32 is supported.
REQ-002 Parameter SEL_W, default 5, meaning select width, equal to clog2(N_IN).
REQ-003 Port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 Port inp, input, 32 bits, meaning data inputs; bit i is input i.
REQ-006 Port sel, input, 5 bits, meaning select, unsigned index 0..31.
REQ-007 Port in_valid, input, 1 bit, meaning inp/sel are to be sampled this cycle.
REQ-008 Port out, output, 1 bit, meaning registered selected bit.
REQ-009 Port out_valid, output, 1 bit, meaning out holds a freshly sampled result.

Function
REQ-010 The combinational select SHALL be mux_val = inp[sel] for every sel value 0..31; there is no out-of-range case.
REQ-011 On a rising clk edge with in_valid=1, out SHALL load mux_val, giving exactly one cycle of latency from sampled inputs to out.
REQ-012 On a rising clk edge with in_valid=0, out SHALL hold its previous value.
REQ-013 out_valid SHALL equal in_valid delayed by one cycle, and SHALL be updated every cycle.
REQ-014 out SHALL depend only on inp[sel] at the sampling edge; the 31 unselected bits SHALL have no effect.
REQ-015 Changes to inp or sel between edges SHALL NOT affect out until the next sampling edge (no combinational path from input to output).
REQ-016 Back-to-back in_valid pulses SHALL each produce a result on consecutive cycles with no bubbles; there is no backpressure.

Reset
REQ-017 While rst_n=0, out=0 and out_valid=0, applied immediately regardless of clk.
REQ-018 Deassertion of rst_n SHALL be synchronized by the surrounding system; the first sample is taken on the first rising edge with rst_n=1.
REQ-019 Reset asserted mid-stream SHALL discard any in-flight result; out_valid SHALL be 0 on the first cycle after release unless in_valid=1 at that edge.

Structure
REQ-020 N_IN and SEL_W SHALL be defined as constants in the shared package mux_pkg.
REQ-021 The combinational selector SHALL be a 5-level binary tree of one sub-module, mux_2to1 (inputs a, b, s; output y), with 31 instances.
REQ-022 Tree level k SHALL use sel[k], with level 0 at the leaves.
REQ-023 The output register stage SHALL be in the top level only; mux_2to1 SHALL be purely combinational.

Verification
REQ-024 Reset: hold rst_n=0 with in_valid=1 and inp=32'hFFFF_FFFF -> out=0 and out_valid=0 throughout reset.
REQ-025 Zero and ones cases:
- inp=32'h0000_0000, sel=0, in_valid=1 -> out=0 and out_valid=1 one cycle later.
- inp=32'hFFFF_FFFF, sel=31 -> out=1 one cycle later.
REQ-026 Walking one: inp=1<<k with sel=k for k=0..31 -> out=1 each cycle. With sel=(k+1)%32 -> out=0 each cycle.
REQ-027 Hold and reset mid-stream:
- inp=32'hA5A5_A5A5, sel=0 sampled (out=1), then in_valid=0 with inp changed to 0 -> out stays 1 and out_valid=0.
- Then assert rst_n=0 mid-cycle -> out=0 immediately.
REQ-028 Random: 15+ cycles of random inp and sel with in_valid=1 -> out equals the reference inp[sel] from the previous cycle on every cycle.
